multi_input_conditioner: RTL and testbench

Parametrised, multi-channel successor to the single-pin input conditioner. Each channel synchronises an asynchronous noisy input into the `clk` domain, debounces it with a configurable stability count, and produces one-cycle rising/falling edge pulses. A per-channel sticky edge-pending flag with acknowledge lets slower consumers, such as a register interface or a state machine, collect edge events without missing pulses. The block sits between the board-level buttons and switches and the synchronous logic.

---
 rtl/multi_input_conditioner.sv | 133 +++++++++++++
 tb/tb_multi_input_conditioner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_input_conditioner.sv
// multi_input_conditioner
//   Multi-channel input conditioner. Each channel synchronises an
//   asynchronous input into the clk domain, debounces it with a stability
//   counter, emits one-cycle rising/falling edge pulses and keeps a sticky
//   edge-pending flag that a slower consumer clears with ack.
//
// Parameters
//   CHANNELS      : number of independent channels (>=1)
//   SYNC_STAGES   : flip-flops per synchroniser chain (>=2)
//   COUNTER_WIDTH : debounce counter width
//   WAIT_TIME     : consecutive differing synchronised cycles before the
//                   conditioned level follows (1..2**COUNTER_WIDTH)
//
// Ports
//   clk          in  1        : system clock, rising-edge active
//   reset        in  1        : synchronous, active-high, clears all state
//   noisysignal  in  CHANNELS : raw asynchronous inputs
//   ack          in  CHANNELS : clears the matching edge_pending bit
//   conditioned  out CHANNELS : debounced, synchronised level
//   positiveedge out CHANNELS : one-cycle pulse on conditioned 0->1
//   negativeedge out CHANNELS : one-cycle pulse on conditioned 1->0
//   edge_pending out CHANNELS : sticky edge flag, cleared by ack
//   any_pending  out 1        : OR of edge_pending
module multi_input_conditioner #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int COUNTER_WIDTH = 3,
  parameter int WAIT_TIME     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisysignal,
  input  logic [CHANNELS-1:0] ack,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic [CHANNELS-1:0] edge_pending,
  output logic                any_pending
);

  // Terminal count: the counter wraps to zero on the cycle the level is taken.
  localparam logic [COUNTER_WIDTH-1:0] LP_CNT_MAX  = COUNTER_WIDTH'(WAIT_TIME - 1);
  localparam logic [COUNTER_WIDTH-1:0] LP_CNT_ONE  = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] LP_CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [CHANNELS-1:0]      LP_CH_ZERO  = {CHANNELS{1'b0}};

  logic [CHANNELS-1:0]      r_sync [SYNC_STAGES];
  logic [COUNTER_WIDTH-1:0] r_cnt  [CHANNELS];
  logic [CHANNELS-1:0]      r_cond;
  logic [CHANNELS-1:0]      r_pos;
  logic [CHANNELS-1:0]      r_neg;
  logic [CHANNELS-1:0]      r_pend;
  logic                     r_any;

  logic [CHANNELS-1:0]      w_sync;
  logic [COUNTER_WIDTH-1:0] w_cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0]      w_cond_nxt;
  logic [CHANNELS-1:0]      w_pos_nxt;
  logic [CHANNELS-1:0]      w_neg_nxt;
  logic [CHANNELS-1:0]      w_pend_nxt;
  logic                     w_any_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Debounce next-state: count cycles where the synchronised input disagrees
  // with the conditioned level; any agreement restarts the count.
  always_comb begin
    w_cond_nxt = r_cond;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_sync[i] == r_cond[i]) begin
        w_cnt_nxt[i] = LP_CNT_ZERO;
      end else if (r_cnt[i] == LP_CNT_MAX) begin
        w_cond_nxt[i] = w_sync[i];
        w_cnt_nxt[i]  = LP_CNT_ZERO;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + LP_CNT_ONE;
      end
    end
  end

  // Edge and pending next-state: a new edge beats a simultaneous ack.
  always_comb begin
    w_pos_nxt  = w_cond_nxt & ~r_cond;
    w_neg_nxt  = ~w_cond_nxt & r_cond;
    w_pend_nxt = w_pos_nxt | w_neg_nxt | (r_pend & ~ack);
    w_any_nxt  = |w_pend_nxt;
  end

  // Synchroniser chains.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= LP_CH_ZERO;
      end
    end else begin
      r_sync[0] <= noisysignal;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // Debounce counters, conditioned level, pulses and pending flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= LP_CNT_ZERO;
      end
      r_cond <= LP_CH_ZERO;
      r_pos  <= LP_CH_ZERO;
      r_neg  <= LP_CH_ZERO;
      r_pend <= LP_CH_ZERO;
      r_any  <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_cond <= w_cond_nxt;
      r_pos  <= w_pos_nxt;
      r_neg  <= w_neg_nxt;
      r_pend <= w_pend_nxt;
      r_any  <= w_any_nxt;
    end
  end

  assign conditioned  = r_cond;
  assign positiveedge = r_pos;
  assign negativeedge = r_neg;
  assign edge_pending = r_pend;
  assign any_pending  = r_any;

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Testbench for multi_input_conditioner: directed steps from the test plan
// followed by a randomised phase, all checked each cycle against a
// sliding-window reference model of the input history.
module tb_multi_input_conditioner;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = 3;
  localparam int WT = 3;
  localparam int HL = SS + WT;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] noisy;
  logic [CH-1:0] ack;
  logic [CH-1:0] cond;
  logic [CH-1:0] pos;
  logic [CH-1:0] neg;
  logic [CH-1:0] pend;
  logic          anyp;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  // Reference model state: hist[j] is the input sampled j edges ago.
  logic [CH-1:0] m_hist [HL];
  logic [CH-1:0] m_cond, m_pos, m_neg, m_pend;
  logic          m_any;

  always #10 clk = ~clk;

  multi_input_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .COUNTER_WIDTH(CW), .WAIT_TIME(WT)
  ) dut (
    .clk(clk), .reset(reset), .noisysignal(noisy), .ack(ack),
    .conditioned(cond), .positiveedge(pos), .negativeedge(neg),
    .edge_pending(pend), .any_pending(anyp)
  );

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_no, obs, exp);
    end
  endtask

  // The conditioned level flips when the synchronised input (the sample
  // taken SS edges ago) has shown the opposite level for the last WT edges.
  task automatic model_step(input logic [CH-1:0] n, input logic [CH-1:0] a, input logic r);
    logic [CH-1:0] nc;
    logic          stable;
    if (r) begin
      for (int k = 0; k < HL; k++) m_hist[k] = '0;
      m_cond = '0; m_pos = '0; m_neg = '0; m_pend = '0; m_any = 1'b0;
    end else begin
      for (int k = HL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = n;
      nc = m_cond;
      for (int c = 0; c < CH; c++) begin
        stable = 1'b1;
        for (int j = SS; j < SS + WT; j++)
          if (m_hist[j][c] == m_cond[c]) stable = 1'b0;
        if (stable) nc[c] = ~m_cond[c];
      end
      m_pos  = nc & ~m_cond;
      m_neg  = ~nc & m_cond;
      m_pend = m_pos | m_neg | (m_pend & ~a);
      m_any  = |m_pend;
      m_cond = nc;
    end
  endtask

  task automatic step(input logic [CH-1:0] n, input logic [CH-1:0] a, input logic r);
    noisy = n;
    ack   = a;
    reset = r;
    @(posedge clk);
    model_step(n, a, r);
    cyc_no++;
    #1;
    check("model_cond", cond, m_cond);
    check("model_pos", pos, m_pos);
    check("model_neg", neg, m_neg);
    check("model_pend", pend, m_pend);
    check("model_any", {3'b000, anyp}, {3'b000, m_any});
  endtask

  initial begin
    logic [CH-1:0] cur;
    logic [CH-1:0] a;
    logic          r;
    int            cnt;

    for (int k = 0; k < HL; k++) m_hist[k] = '0;
    m_cond = '0; m_pos = '0; m_neg = '0; m_pend = '0; m_any = 1'b0;

    // Reset with inputs high.
    cur = 4'hF;
    step(cur, 4'h0, 1'b1);
    step(cur, 4'h0, 1'b1);
    check("rst_outs", cond | pos | neg | pend, 4'h0);
    check("rst_any", {3'b000, anyp}, 4'h0);

    // Release: edge after five cycles.
    for (int i = 0; i < 5; i++) begin
      step(cur, 4'h0, 1'b0);
      if (i < 4) check("rel_quiet", pos, 4'h0);
    end
    check("rel_pos", pos, 4'hF);
    check("rel_cond", cond, 4'hF);
    check("rel_pend", pend, 4'hF);
    check("rel_any", {3'b000, anyp}, 4'h1);
    step(cur, 4'h0, 1'b0);
    check("rel_width", pos, 4'h0);
    step(cur, 4'hF, 1'b0);
    check("ack_all", pend, 4'h0);
    check("ack_any", {3'b000, anyp}, 4'h0);

    // Clean step on ch0.
    cur = 4'hE;
    repeat (6) step(cur, 4'h0, 1'b0);
    step(cur, 4'hF, 1'b0);
    cur = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step(cur, 4'h0, 1'b0);
      check("clean_pos0", pos & 4'h1, (i == 4) ? 4'h1 : 4'h0);
      check("clean_others", (pos | neg) & 4'hE, 4'h0);
    end
    step(cur, 4'hF, 1'b0);

    // Bounce on ch1 from a low level, then hold high.
    cur[1] = 1'b0;
    repeat (6) step(cur, 4'h0, 1'b0);
    step(cur, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cur[1] = ~cur[1];
      step(cur, 4'h0, 1'b0);
      check("bounce_quiet", (pos | neg) & 4'h2, 4'h0);
    end
    cur[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(cur, 4'h0, 1'b0);
      if (pos[1]) cnt++;
      check("bounce_pos1", pos & 4'h2, (i == 4) ? 4'h2 : 4'h0);
    end
    check("bounce_count", 4'(cnt), 4'h1);

    // Two-cycle glitch on ch2.
    cur[2] = 1'b0;
    step(cur, 4'hF, 1'b0);
    step(cur, 4'h0, 1'b0);
    cur[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(cur, 4'h0, 1'b0);
      check("glitch_quiet", (pos | neg) & 4'h4, 4'h0);
    end

    // Falling edge on ch3, then ack.
    step(cur, 4'hF, 1'b0);
    cur[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(cur, 4'h0, 1'b0);
      check("fall_neg3", neg & 4'h8, (i == 4) ? 4'h8 : 4'h0);
    end
    check("fall_pend", pend, 4'h8);
    check("fall_any", {3'b000, anyp}, 4'h1);
    step(cur, 4'h8, 1'b0);
    check("fall_ack", pend, 4'h0);
    check("fall_any_clr", {3'b000, anyp}, 4'h0);

    // Ack collides with a new edge on ch0.
    cur[0] = 1'b0;
    for (int i = 0; i < 5; i++) step(cur, 4'h1, 1'b0);
    check("coll_neg0", neg & 4'h1, 4'h1);
    check("coll_pend0", pend & 4'h1, 4'h1);
    step(cur, 4'h1, 1'b0);
    check("coll_clr0", pend & 4'h1, 4'h0);

    // Reset while ch2 is mid-count.
    cur[2] = 1'b0;
    repeat (6) step(cur, 4'h0, 1'b0);
    step(cur, 4'hF, 1'b0);
    cur[2] = 1'b1;
    repeat (4) step(cur, 4'h0, 1'b0);
    step(cur, 4'h0, 1'b1);
    check("midrst_outs", cond | pos | neg | pend, 4'h0);
    check("midrst_any", {3'b000, anyp}, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(cur, 4'h0, 1'b0);
      check("midrst_pos2", pos & 4'h4, (i == 4) ? 4'h4 : 4'h0);
    end

    // Randomised phase with slowly changing inputs.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 3) == 0) cur[c] = ~cur[c];
      for (int c = 0; c < CH; c++)
        a[c] = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(cur, a, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
